// File: rtl/dispatch3.sv
`default_nettype none
// ============================================================================
// Module   : dispatch3
// Function : Round-robin stream dispatcher in front of the three-way demux.
//            A 2-entry FIFO buffers the input stream. Each head word is bound
//            to one ready lane (0..2), and the word, lane and one-hot valid
//            are held until that lane accepts.
//            Optional macro DISPATCH3_COUNT_EN adds per-lane saturating
//            16-bit accept counters (cnt0..cnt2).
// Revision : 1.0 - initial release
// ============================================================================
module dispatch3 #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [width-1:0] in_data,
    output logic             in_ready,
    input  logic [2:0]       out_ready,
    output logic [1:0]       select,
    output logic [width-1:0] f,
    output logic [2:0]       out_valid
`ifdef DISPATCH3_COUNT_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2
`endif
);

    localparam logic [1:0] c_fifo_depth = 2'd2;

    // FIFO storage and pointers
    logic [width-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    // Output holding register
    logic             r_hold;
    logic [1:0]       r_select;
    logic [width-1:0] r_f;
    logic [1:0]       r_rr;

    logic             w_push;
    logic             w_accept;
    logic             w_load;
    logic [1:0]       w_lane;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready = (r_count != c_fifo_depth);
    assign w_push   = in_valid && in_ready;
    assign w_accept = r_hold && out_ready[r_select];
    assign w_load   = (r_count != 2'd0) && (!r_hold || w_accept) && (|out_ready);

    // Lane search order after the last grant: rr+1, rr+2, then rr itself
    always_comb begin
        w_lane = r_rr;
        case (r_rr)
            2'd0: begin
                if (out_ready[1])      w_lane = 2'd1;
                else if (out_ready[2]) w_lane = 2'd2;
                else                   w_lane = 2'd0;
            end
            2'd1: begin
                if (out_ready[2])      w_lane = 2'd2;
                else if (out_ready[0]) w_lane = 2'd0;
                else                   w_lane = 2'd1;
            end
            default: begin
                if (out_ready[0])      w_lane = 2'd0;
                else if (out_ready[1]) w_lane = 2'd1;
                else                   w_lane = 2'd2;
            end
        endcase
    end

    // FIFO data storage; contents are don't-care while the entry is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; a pop is exactly a load of the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_load) r_rptr <= ~r_rptr;
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output register: reload on load, otherwise drop hold on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold   <= 1'b0;
            r_select <= 2'd0;
            r_f      <= '0;
            r_rr     <= 2'd2;
        end else if (w_load) begin
            r_hold   <= 1'b1;
            r_select <= w_lane;
            r_f      <= r_mem[r_rptr];
            r_rr     <= w_lane;
        end else if (w_accept) begin
            r_hold   <= 1'b0;
        end
    end

    assign select    = r_select;
    assign f         = r_f;
    assign out_valid = r_hold ? (3'b001 << r_select) : 3'b000;

`ifdef DISPATCH3_COUNT_EN
    logic [15:0] r_cnt [3];

    // Per-lane accept counters, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) r_cnt[i] <= 16'd0;
        end else if (w_accept) begin
            for (int i = 0; i < 3; i++) begin
                if ((r_select == 2'(i)) && (r_cnt[i] != 16'hFFFF)) begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign cnt2 = r_cnt[2];
`endif

endmodule
`default_nettype wire

// File: tb/tb_dispatch3.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch3
// Function : Self-checking bench for dispatch3. A queue-based model of the
//            dispatcher is compared against the DUT every cycle, and directed
//            scenarios carry hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [2:0] out_ready;
    logic [1:0] select;
    logic [7:0] f;
    logic [2:0] out_valid;
`ifdef DISPATCH3_COUNT_EN
    logic [15:0] cnt0, cnt1, cnt2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dispatch3 #(.width(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .select    (select),
        .f         (f),
        .out_valid (out_valid)
`ifdef DISPATCH3_COUNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];
    bit         m_hold;
    int         m_sel;
    logic [7:0] m_f;
    int         m_rr;
    int         m_cnt[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_hold = 0;
            m_sel  = 0;
            m_f    = 8'h00;
            m_rr   = 2;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else begin
            bit push, acc, load;
            int lane;
            push = in_valid && (m_q.size() < 2);
            acc  = m_hold && out_ready[m_sel];
            load = (m_q.size() > 0) && (!m_hold || acc) && (out_ready != 3'b000);
            if (acc && m_cnt[m_sel] < 65535) m_cnt[m_sel]++;
            if (load) begin
                lane = m_rr;
                for (int k = 1; k <= 3; k++) begin
                    if (out_ready[(m_rr + k) % 3]) begin
                        lane = (m_rr + k) % 3;
                        break;
                    end
                end
                m_f    = m_q.pop_front();
                m_sel  = lane;
                m_rr   = lane;
                m_hold = 1;
            end else if (acc) begin
                m_hold = 0;
            end
            if (push) m_q.push_back(in_data);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
            chk("out_valid", 32'(out_valid), m_hold ? 32'(1 << m_sel) : 32'd0);
            chk("select", 32'(select), 32'(m_sel));
            chk("f", 32'(f), 32'(m_f));
`ifdef DISPATCH3_COUNT_EN
            chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
            chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
            chk("cnt2", 32'(cnt2), 32'(m_cnt[2]));
`endif
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge
    task automatic step(input logic iv, input logic [7:0] id, input logic [2:0] ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 3'b000;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst select", 32'(select), 32'd0);
        chk("rst f", 32'(f), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream, all lanes ready: lanes 0,1,2,0
        step(1'b1, 8'h11, 3'b111);
        chk("t1 ov after push", 32'(out_valid), 32'd0);
        step(1'b1, 8'h22, 3'b111);
        chk("t1 ov w0", 32'(out_valid), 32'b001);
        chk("t1 f w0", 32'(f), 32'h11);
        step(1'b1, 8'h33, 3'b111);
        chk("t1 ov w1", 32'(out_valid), 32'b010);
        chk("t1 f w1", 32'(f), 32'h22);
        step(1'b1, 8'h44, 3'b111);
        chk("t1 ov w2", 32'(out_valid), 32'b100);
        chk("t1 f w2", 32'(f), 32'h33);
        step(1'b0, 8'h00, 3'b111);
        chk("t1 ov w3", 32'(out_valid), 32'b001);
        chk("t1 f w3", 32'(f), 32'h44);
        step(1'b0, 8'h00, 3'b111);
        chk("t1 ov idle", 32'(out_valid), 32'd0);

        // No lane ready: FIFO fills, third word waits upstream
        step(1'b1, 8'hA1, 3'b000);
        chk("t2 in_ready 1", 32'(in_ready), 32'd1);
        step(1'b1, 8'hA2, 3'b000);
        chk("t2 in_ready full", 32'(in_ready), 32'd0);
        step(1'b1, 8'hA3, 3'b000);
        chk("t2 ov none", 32'(out_valid), 32'd0);
        step(1'b1, 8'hA3, 3'b111);
        chk("t2 sel a1", 32'(select), 32'd1);
        chk("t2 f a1", 32'(f), 32'hA1);
        step(1'b1, 8'hA3, 3'b111);
        chk("t2 f a2", 32'(f), 32'hA2);
        step(1'b0, 8'h00, 3'b111);
        chk("t2 f a3", 32'(f), 32'hA3);
        chk("t2 sel a3", 32'(select), 32'd0);
        step(1'b0, 8'h00, 3'b111);

        // Held word on lane 1 stays put while only lanes 0 and 2 are ready
        step(1'b1, 8'hA5, 3'b010);
        step(1'b0, 8'h00, 3'b010);
        chk("t3 ov load", 32'(out_valid), 32'b010);
        step(1'b1, 8'h5A, 3'b101);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 3'b101);
            chk("t3 sel hold", 32'(select), 32'd1);
            chk("t3 f hold", 32'(f), 32'hA5);
        end
        step(1'b0, 8'h00, 3'b010);
        chk("t3 f next", 32'(f), 32'h5A);
        step(1'b0, 8'h00, 3'b000);
        step(1'b0, 8'h00, 3'b010);
        chk("t3 ov idle", 32'(out_valid), 32'd0);

        // Only lane 0 ready: pointer moves to 0 and stays there
        step(1'b1, 8'h61, 3'b001);
        step(1'b1, 8'h62, 3'b001);
        chk("t4 sel 61", 32'(select), 32'd0);
        step(1'b0, 8'h00, 3'b001);
        chk("t4 sel 62", 32'(select), 32'd0);
        chk("t4 f 62", 32'(f), 32'h62);
        step(1'b0, 8'h00, 3'b001);

        // Reset while holding a word with the FIFO full
        step(1'b1, 8'h71, 3'b000);
        step(1'b1, 8'h72, 3'b000);
        step(1'b0, 8'h00, 3'b001);
        step(1'b1, 8'h73, 3'b000);
        chk("t5 pre ov", 32'(out_valid), 32'b001);
        chk("t5 pre in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst ov", 32'(out_valid), 32'd0);
        chk("t5 rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h81, 3'b111);
        step(1'b0, 8'h00, 3'b111);
        chk("t5 post ov", 32'(out_valid), 32'b001);
        chk("t5 post f", 32'(f), 32'h81);
        step(1'b0, 8'h00, 3'b111);

`ifdef DISPATCH3_COUNT_EN
        // Three accepts on lane 2
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'(8'h90 + i), 3'b100);
            step(1'b0, 8'h00, 3'b100);
            step(1'b0, 8'h00, 3'b100);
        end
        chk("t6 cnt2", 32'(cnt2), 32'd3);
        chk("t6 cnt0", 32'(cnt0), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
